// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the uP16 instruction-memory loader.
// Word layout matches the core's 18-bit instruction format.
package imem_loader_pkg;

  localparam int IADDR_W = 10;
  localparam int IWORD_W = 18;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    CNT_H,
    CNT_L,
    B0,
    B1,
    B2,
    WR,
    CHK,
    DONE
  } state_t;

  // Only the low two bits of byte0 carry payload; the loader rejects the rest.
  function automatic logic [IWORD_W-1:0] pack_word(input logic [1:0] b0_lo,
                                                   input logic [7:0] b1,
                                                   input logic [7:0] b2);
    return {b0_lo, b1, b2};
  endfunction

endpackage

// File: rtl/ld_word_pack.sv
// Byte assembler for one 18-bit instruction word: holds byte0/byte1 and
// combines them with the byte2 lane as it arrives, so the word is ready on accept.
module ld_word_pack
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         byte_in,
  input  logic               ld_b0,
  input  logic               ld_b1,
  output logic [IWORD_W-1:0] word,
  output logic               b0_range_err
);

  logic [1:0] b0_q;
  logic [7:0] b1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b0_q <= '0;
      b1_q <= '0;
    end else begin
      if (ld_b0) b0_q <= byte_in[1:0];
      if (ld_b1) b1_q <= byte_in;
    end
  end

  assign word         = pack_word(b0_q, b1_q, byte_in);
  assign b0_range_err = |byte_in[7:2];

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the uP16 instruction memory; holds the core
// off the memory while loading. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic               Clk_In,
  input  logic               Rst_N_In,
  input  logic [7:0]         Byte_In,
  input  logic               Byte_Valid_In,
  output logic               Byte_Ready_Out,
  output logic               Wr_En_Out,
  output logic [IADDR_W-1:0] Wr_Add_Out,
  output logic [IWORD_W-1:0] Wr_Data_Out,
  output logic               Cpu_Hold_Out,
  output logic               Done_Out,
  output logic               Err_Out
);

  state_t               state;
  logic [IADDR_W-1:0]   word_cnt;
  logic [1:0]           cnt_hi;
  logic                 accept;
  logic                 ld_b0;
  logic                 ld_b1;
  logic [IWORD_W-1:0]   packed_word;
  logic                 b0_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]           chk_acc;
`endif

  assign accept = Byte_Valid_In & Byte_Ready_Out;
  assign ld_b0  = accept && (state == B0);
  assign ld_b1  = accept && (state == B1);

  ld_word_pack u_pack (
    .clk          (Clk_In),
    .rst_n        (Rst_N_In),
    .byte_in      (Byte_In),
    .ld_b0        (ld_b0),
    .ld_b1        (ld_b1),
    .word         (packed_word),
    .b0_range_err (b0_err)
  );

  // word_cnt holds words remaining minus one, so zero in WR marks the last word.
  always_ff @(posedge Clk_In or negedge Rst_N_In) begin
    if (!Rst_N_In) begin
      state          <= IDLE;
      word_cnt       <= '0;
      cnt_hi         <= '0;
      Byte_Ready_Out <= 1'b0;
      Wr_En_Out      <= 1'b0;
      Wr_Add_Out     <= '0;
      Wr_Data_Out    <= '0;
      Cpu_Hold_Out   <= 1'b0;
      Done_Out       <= 1'b0;
      Err_Out        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_acc        <= '0;
`endif
    end else begin
      Wr_En_Out <= 1'b0;
      Done_Out  <= 1'b0;
      case (state)
        IDLE: begin
          Byte_Ready_Out <= 1'b1;
          Cpu_Hold_Out   <= 1'b0;
          if (accept && (Byte_In == HDR_BYTE)) begin
            state        <= CNT_H;
            Err_Out      <= 1'b0;
            Cpu_Hold_Out <= 1'b1;
          end
        end

        CNT_H: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc <= Byte_In;
`endif
            if (|Byte_In[7:2]) begin
              state        <= IDLE;
              Err_Out      <= 1'b1;
              Cpu_Hold_Out <= 1'b0;
            end else begin
              cnt_hi <= Byte_In[1:0];
              state  <= CNT_L;
            end
          end
        end

        CNT_L: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ Byte_In;
`endif
            word_cnt   <= {cnt_hi, Byte_In};
            Wr_Add_Out <= '0;
            state      <= B0;
          end
        end

        B0: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ Byte_In;
`endif
            if (b0_err) begin
              state        <= IDLE;
              Err_Out      <= 1'b1;
              Cpu_Hold_Out <= 1'b0;
            end else begin
              state <= B1;
            end
          end
        end

        B1: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ Byte_In;
`endif
            state <= B2;
          end
        end

        B2: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ Byte_In;
`endif
            Wr_Data_Out    <= packed_word;
            Wr_En_Out      <= 1'b1;
            Byte_Ready_Out <= 1'b0;
            state          <= WR;
          end
        end

        WR: begin
          if (word_cnt == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            Byte_Ready_Out <= 1'b1;
            state          <= CHK;
`else
            Done_Out       <= 1'b1;
            state          <= DONE;
`endif
          end else begin
            word_cnt       <= word_cnt - 1'b1;
            Wr_Add_Out     <= Wr_Add_Out + 1'b1;
            Byte_Ready_Out <= 1'b1;
            state          <= B0;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            if (Byte_In == chk_acc) begin
              Done_Out       <= 1'b1;
              Byte_Ready_Out <= 1'b0;
              state          <= DONE;
            end else begin
              Err_Out      <= 1'b1;
              Cpu_Hold_Out <= 1'b0;
              state        <= IDLE;
            end
          end
        end
`endif

        DONE: begin
          Wr_Add_Out     <= '0;
          Byte_Ready_Out <= 1'b1;
          Cpu_Hold_Out   <= 1'b0;
          state          <= IDLE;
        end

        default: begin
          Byte_Ready_Out <= 1'b1;
          Cpu_Hold_Out   <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the uP16 instruction memory (1024 x 18-bit, 10-bit address).
- Receives a framed byte stream from a host link over a valid/ready handshake.
- Packs every 3 bytes into one 18-bit instruction word and drives the memory write port (address, data, write enable).
- Holds the core off the instruction memory while a load is in progress, then pulses done.

Parameters:
- IADDR_W, 10, instruction memory address width.
- IWORD_W, 18, instruction word width.
- HDR_BYTE, 8'hA5, frame start byte.

Ports:
- Clk_In  input  1  system clock; all logic on rising edge.
- Rst_N_In  input  1  asynchronous, active-low reset.
- Byte_In  input  8  incoming stream byte.
- Byte_Valid_In  input  1  Byte_In is valid.
- Byte_Ready_Out  output  1  loader accepts a byte this cycle; transfer occurs when valid and ready are both high.
- Wr_En_Out  output  1  one-cycle memory write strobe.
- Wr_Add_Out  output  IADDR_W  write address.
- Wr_Data_Out  output  IWORD_W  write data: bits 17:16 from byte0[1:0], bits 15:8 from byte1, bits 7:0 from byte2.
- Cpu_Hold_Out  output  1  keep the core stalled and in reset while loading.
- Done_Out  output  1  one-cycle pulse on successful load.
- Err_Out  output  1  sticky error flag.

Behaviour:
- Clock and reset: one clock, Clk_In. Reset Rst_N_In is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, address counter 0, word counter 0.
- Frame format: HDR_BYTE, CNT_HI, CNT_LO, then N x {byte0, byte1, byte2}.
  - N = {CNT_HI[1:0], CNT_LO} + 1, giving 1..1024 words.
  - Words are written to addresses 0..N-1.
- States:
  - IDLE: Ready=1. Byte equal to HDR_BYTE -> CNT_H and Err_Out clears. Any other byte is discarded and the state stays IDLE.
  - CNT_H: Ready=1. Byte accepted -> CNT_L. If CNT_HI[7:2]!=0: set Err, go to IDLE.
  - CNT_L: Ready=1. Byte accepted -> B0. Load the word counter; address=0.
  - B0: Ready=1. Byte accepted -> B1. If byte0[7:2]!=0: set Err, go to IDLE.
  - B1: Ready=1. Byte accepted -> B2.
  - B2: Ready=1. Byte accepted -> WR.
  - WR: Ready=0.
    - Wr_En_Out=1 for exactly one cycle with the registered address and data; there is one cycle of latency from acceptance of byte2 to the write.
    - After the write, address increments. If this was the last word -> DONE, else -> B0.
  - DONE: Done_Out=1 for one cycle, Wr_Add_Out reset to 0 -> IDLE.
- Cpu_Hold_Out: 1 in every state except IDLE. It deasserts in the same cycle as the return to IDLE (the cycle after the Done pulse or the error).
- Err_Out: set on any framing error; remains set until the next HDR_BYTE is accepted or reset.
- Partial program: on error, words already written stay in memory; no rollback.
- Address wrap: impossible by construction, since N ≤ 1024 and address never exceeds N-1.
- Valid low in any receive state: the loader waits indefinitely; no timeout.
- Reset mid-load: immediately to IDLE. Wr_En_Out drops asynchronously and Cpu_Hold_Out deasserts.
- Wr_Data_Out holds its last value between writes. Wr_Add_Out holds between writes and resets to 0 after DONE.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A trailing CHK byte follows the last word; state CHK (Ready=1) is entered from WR instead of DONE.
  - CHK must equal the XOR of all bytes from CNT_HI through the final byte2.
  - Match -> DONE. Mismatch -> set Err, no Done pulse, go to IDLE; written words remain.
- Undefined: no CHK state or byte; WR goes straight to DONE after the last word. The running-XOR register is not built.

Decomposition:
- Package imem_loader_pkg:
  - state enum (IDLE, CNT_H, CNT_L, B0, B1, B2, WR, CHK, DONE);
  - HDR_BYTE, IADDR_W, IWORD_W constants;
  - function composing {byte0[1:0], byte1, byte2}.
- Sub-module ld_word_pack: 3-byte shift/assemble register with load strobes and a byte0 range-error output. The FSM and counters stay in imem_loader.

Test Plan:
- Load 2 words: A5,00,01, then 00,E0,71, then 01,C8,01 -> Wr_En at add 0 data 0x0E071 and add 1 data 0x1C801; each write 1 cycle after byte2; Done pulse; Hold low next cycle.
- Full load: CNT=03,FF, 1024 words of incrementing pattern -> 1024 writes, last at add 0x3FF, exactly one Done, no error.
- Framing error: A5,00,00, then byte0=0x04 -> Err=1, Hold=0, no write. Next A5 clears Err.
- Junk before header: bytes 00,FF,5A then a valid 1-word frame -> junk ignored, single write at add 0.
- Backpressure/gaps: Valid toggled randomly, and Valid held high during WR -> no byte lost, since Ready=0 in WR; data intact.
- Async reset asserted between byte1 and byte2 of word 3 -> outputs 0 immediately; a new frame loads from add 0. With CHECKSUM_EN, a wrong CHK byte -> Err, no Done.
